// File: rtl/i2c_byte_master.sv
// i2c_byte_master: byte-level I2C master engine (START/RS/WRITE/READ/STOP) with
// runtime phase divisor, clock stretching and arbitration-loss detection.
module i2c_byte_master #(
  parameter int DIV_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DIV_W-1:0] divisor,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd,
  input  logic [7:0]       wr_data,
  input  logic             rd_nack,
  output logic             rsp_valid,
  output logic [7:0]       rd_data,
  output logic             ack_rx,
  output logic             arb_lost,
  output logic             err,
  output logic             busy,
  input  logic             scl_i,
  input  logic             sda_i,
  output logic             scl_oe,
  output logic             sda_oe
);
  localparam logic [1:0] CMD_START = 2'd0;
  localparam logic [1:0] CMD_WRITE = 2'd1;
  localparam logic [1:0] CMD_STOP  = 2'd3;

  typedef enum logic [3:0] {
    S_IDLE, S_START1, S_START2, S_HOLD, S_RS1,
    S_BIT_LO, S_BIT_HI, S_STOP1, S_STOP2, S_STOP3
  } state_t;

  state_t                 r_state, w_next;
  logic [DIV_W-1:0]       r_ctr, r_div;
  logic [SYNC_STAGES-1:0] r_scl_s, r_sda_s;
  logic [7:0]             r_sh, r_rd;
  logic [3:0]             r_bit;
  logic                   r_wr, r_nack, r_rsp, r_err, r_arb, r_ack, r_busy, r_hold_sda;
  logic                   w_scl, w_sda, w_accept, w_rel, w_stall, w_tick, w_last, w_drive, w_arb;

  assign w_scl    = r_scl_s[SYNC_STAGES-1];
  assign w_sda    = r_sda_s[SYNC_STAGES-1];
  assign w_accept = cmd_valid && cmd_ready;
  assign w_rel    = r_state inside {S_START1, S_STOP2, S_STOP3, S_BIT_HI};
  assign w_stall  = w_rel && !w_scl;
  assign w_tick   = !w_stall && (r_ctr == r_div);
  assign w_last   = (r_bit == 4'd8);
  // Slot 9 of a WRITE releases SDA for the slave ACK; READ drives only the ACK slot.
  assign w_drive  = r_wr ? (!w_last && !r_sh[7]) : (w_last && !r_nack);
  assign w_arb    = w_tick && !w_sda &&
                    (r_state == S_START1 || (r_state == S_BIT_HI && r_wr && !w_last && r_sh[7]));

  assign rsp_valid = r_rsp;
  assign rd_data   = r_rd;
  assign ack_rx    = r_ack;
  assign arb_lost  = r_arb;
  assign err       = r_err;
  assign busy      = r_busy;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   w_next = (w_accept && cmd == CMD_START) ? S_START1 : S_IDLE;
      S_HOLD:   w_next = !w_accept ? S_HOLD : (cmd == CMD_START) ? S_RS1 :
                         (cmd == CMD_STOP) ? S_STOP1 : S_BIT_LO;
      S_RS1:    w_next = w_tick ? S_START1 : S_RS1;
      S_START1: w_next = w_arb ? S_IDLE : w_tick ? S_START2 : S_START1;
      S_START2: w_next = w_tick ? S_HOLD : S_START2;
      S_BIT_LO: w_next = w_tick ? S_BIT_HI : S_BIT_LO;
      S_BIT_HI: w_next = w_arb ? S_IDLE : !w_tick ? S_BIT_HI : w_last ? S_HOLD : S_BIT_LO;
      S_STOP1:  w_next = w_tick ? S_STOP2 : S_STOP1;
      S_STOP2:  w_next = w_tick ? S_STOP3 : S_STOP2;
      S_STOP3:  w_next = w_tick ? S_IDLE : S_STOP3;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = !reset && (r_state == S_IDLE || r_state == S_HOLD);
    scl_oe    = r_state inside {S_HOLD, S_RS1, S_BIT_LO, S_STOP1};
    sda_oe    = (r_state inside {S_START2, S_STOP1, S_STOP2}) ? 1'b1 :
                (r_state == S_HOLD) ? r_hold_sda :
                (r_state inside {S_BIT_LO, S_BIT_HI}) ? w_drive : 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_scl_s    <= '1;
      r_sda_s    <= '1;
      r_ctr      <= '0;
      r_div      <= '0;
      r_sh       <= '0;
      r_rd       <= '0;
      r_bit      <= '0;
      r_wr       <= 1'b0;
      r_nack     <= 1'b0;
      r_rsp      <= 1'b0;
      r_err      <= 1'b0;
      r_arb      <= 1'b0;
      r_ack      <= 1'b0;
      r_busy     <= 1'b0;
      r_hold_sda <= 1'b0;
    end else begin
      r_scl_s <= {r_scl_s[SYNC_STAGES-2:0], scl_i};
      r_sda_s <= {r_sda_s[SYNC_STAGES-2:0], sda_i};
      r_ctr   <= (r_state == S_IDLE || r_state == S_HOLD || w_stall || w_tick) ? '0 : r_ctr + 1'b1;
      r_rsp   <= 1'b0;
      if (w_accept) begin
        r_div  <= divisor;
        r_wr   <= (cmd == CMD_WRITE);
        r_sh   <= wr_data;
        r_nack <= rd_nack;
        r_bit  <= '0;
        r_arb  <= 1'b0;
        r_ack  <= 1'b0;
        r_err  <= (r_state == S_IDLE && cmd != CMD_START);
        r_rsp  <= (r_state == S_IDLE && cmd != CMD_START);
      end
      if (w_arb) begin
        r_arb  <= 1'b1;
        r_rsp  <= 1'b1;
        r_busy <= 1'b0;
      end else if (w_tick) begin
        case (r_state)
          S_START1: r_busy <= 1'b1;
          S_START2: begin
            r_rsp      <= 1'b1;
            r_hold_sda <= 1'b1;
          end
          S_BIT_HI: begin
            if (w_last) begin
              r_rsp      <= 1'b1;
              r_hold_sda <= w_drive;
              if (r_wr) r_ack <= w_sda;
              else      r_rd  <= r_sh;
            end else begin
              r_sh  <= {r_sh[6:0], w_sda};
              r_bit <= r_bit + 4'd1;
            end
          end
          S_STOP3: begin
            r_rsp  <= 1'b1;
            r_busy <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_i2c_byte_master.sv
// tb_i2c_byte_master: scoreboard bench for i2c_byte_master with a small
// reactive slave (ACK, read data, clock stretch, arbitration collision).
module tb_i2c_byte_master;
  localparam int SS = 2;

  typedef struct packed {
    logic       err;
    logic       arb;
    logic       ack;
    logic [7:0] rd;
    logic       busy;
  } rsp_t;

  logic        clk = 1'b0, reset = 1'b1;
  logic [15:0] divisor = 16'd3;
  logic        cmd_valid = 1'b0, rd_nack = 1'b0;
  logic [1:0]  cmd = 2'd0;
  logic [7:0]  wr_data = 8'h00;
  logic        cmd_ready, rsp_valid, ack_rx, arb_lost, err, busy, scl_oe, sda_oe;
  logic [7:0]  rd_data;
  logic        scl_i, sda_i;
  logic        slave_low = 1'b0, force_low = 1'b0, stretch = 1'b0;

  assign scl_i = !stretch;
  assign sda_i = !(sda_oe || slave_low || force_low);

  i2c_byte_master #(.DIV_W(16), .SYNC_STAGES(SS)) dut (
    .clk(clk), .reset(reset), .divisor(divisor), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .cmd(cmd), .wr_data(wr_data), .rd_nack(rd_nack),
    .rsp_valid(rsp_valid), .rd_data(rd_data), .ack_rx(ack_rx), .arb_lost(arb_lost),
    .err(err), .busy(busy), .scl_i(scl_i), .sda_i(sda_i), .scl_oe(scl_oe), .sda_oe(sda_oe)
  );

  always #5 clk = ~clk;

  rsp_t       q[$];
  rsp_t       m_exp;
  logic [7:0] m_rd = 8'h00;
  logic [7:0] rbyte = 8'h00;
  int         n_tests = 0, n_fail = 0;
  int         lat, falls;
  logic [7:0] pat, oe_log;
  logic       scl_any, sda_any;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic rsp_t mk(input logic e, input logic a, input logic k, input logic b);
    return '{err: e, arb: a, ack: k, rd: m_rd, busy: b};
  endfunction

  always @(negedge clk) begin
    if (!reset && rsp_valid) begin
      check("rsp_pending", q.size() != 0, 1);
      if (q.size() != 0) begin
        m_exp = q.pop_front();
        check("rsp_fields", {err, arb_lost, ack_rx, rd_data, busy}, m_exp);
      end
    end
  end

  task automatic issue(input logic [1:0] c, input logic [7:0] d, input logic nk,
                       input logic [15:0] dv, input rsp_t e);
    int t = 0;
    while (!cmd_ready && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    check("cmd_ready", cmd_ready, 1);
    cmd = c; wr_data = d; rd_nack = nk; divisor = dv; cmd_valid = 1'b1;
    q.push_back(e);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  // Modes: 0 passive, 1 ACK in slot 9, 2 READ data, 3 stretch bit 3, 4 collide in bit 2.
  // At one-clock phases the two-flop synchroniser spans a whole slot, so the read
  // model presents each bit from the previous SCL rise onwards.
  task automatic run(input int md, input int budget, input int stop_f);
    logic prev;
    int   hc = 0;
    logic fell, rose;
    prev = scl_oe; falls = 0; lat = 0; pat = 8'h00;
    oe_log = {6'b0, scl_oe, sda_oe}; scl_any = scl_oe; sda_any = sda_oe;
    while (!rsp_valid && lat < budget && !(stop_f != 0 && falls == stop_f)) begin
      @(posedge clk); #1;
      lat++;
      fell = prev && !scl_oe;
      rose = !prev && scl_oe;
      prev = scl_oe;
      if (fell) falls++;
      if (fell && falls <= 8) pat = {pat[6:0], sda_i};
      if ({scl_oe, sda_oe} != oe_log[1:0]) oe_log = {oe_log[5:0], scl_oe, sda_oe};
      scl_any |= scl_oe;
      sda_any |= sda_oe;
      if (md == 1 && rose && falls == 8) slave_low = 1'b1;
      if (md == 2) slave_low = (falls < 8) && !rbyte[7-falls];
      if (md == 3) begin
        if (rose && falls == 2) stretch = 1'b1;
        if (stretch && fell && falls == 3) hc = 0;
        else if (stretch && falls == 3) begin
          hc++;
          if (hc == 20) stretch = 1'b0;
        end
      end
      if (md == 4 && fell && falls == 2) force_low = 1'b1;
    end
    slave_low = 1'b0; force_low = 1'b0; stretch = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_outputs", {cmd_ready, rsp_valid, rd_data, ack_rx, arb_lost, err, busy, scl_oe, sda_oe}, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("ready_after_rst", cmd_ready, 1);

    issue(2'd0, 8'h00, 1'b0, 16'd3, mk(0, 0, 0, 1)); run(0, 200, 0);
    check("start_lat", lat, 8);
    issue(2'd1, 8'hA5, 1'b0, 16'd3, mk(0, 0, 0, 1)); run(1, 400, 0);
    check("wr_lat", lat, 72);
    check("wr_pattern", pat, 8'hA5);
    issue(2'd3, 8'h00, 1'b0, 16'd3, mk(0, 0, 0, 0)); run(0, 200, 0);
    check("stop_lat", lat, 12);

    issue(2'd0, 8'h00, 1'b0, 16'd0, mk(0, 0, 0, 1)); run(0, 50, 0);
    check("start_lat_div0", lat, 2);
    rbyte = 8'h3C; slave_low = !rbyte[7]; m_rd = 8'h3C;
    issue(2'd2, 8'h00, 1'b1, 16'd0, mk(0, 0, 0, 1)); run(2, 200, 0);
    check("rd_lat", lat, 18);
    check("rd_data", rd_data, 8'h3C);
    check("rd_sda_released", sda_any, 0);
    issue(2'd3, 8'h00, 1'b0, 16'd0, mk(0, 0, 0, 0)); run(0, 50, 0);
    check("stop_lat_div0", lat, 3);

    issue(2'd0, 8'h00, 1'b0, 16'd3, mk(0, 0, 0, 1)); run(0, 200, 0);
    issue(2'd1, 8'h5A, 1'b0, 16'd3, mk(0, 0, 1, 1)); run(3, 400, 0);
    check("stretch_lat", lat, 72 + 20 + SS);
    issue(2'd3, 8'h00, 1'b0, 16'd3, mk(0, 0, 0, 0)); run(0, 200, 0);

    issue(2'd0, 8'h00, 1'b0, 16'd3, mk(0, 0, 0, 1)); run(0, 200, 0);
    issue(2'd1, 8'hFF, 1'b0, 16'd3, mk(0, 1, 0, 0));
    divisor = 16'd7;
    run(4, 200, 0);
    check("arb_lat", lat, 16);
    check("arb_lines", {scl_oe, sda_oe, busy}, 0);
    @(posedge clk); #1;
    check("arb_ready", cmd_ready, 1);

    issue(2'd1, 8'h00, 1'b0, 16'd3, mk(1, 0, 0, 0)); run(0, 50, 0);
    check("err_lat", lat, 0);
    @(posedge clk); #1;
    check("err_pulse", rsp_valid, 0);
    check("err_held", err, 1);
    check("err_lines", scl_any | sda_any | scl_oe | sda_oe, 0);

    issue(2'd0, 8'h00, 1'b0, 16'd3, mk(0, 0, 0, 1)); run(0, 200, 0);
    issue(2'd1, 8'h12, 1'b0, 16'd3, mk(0, 0, 0, 1)); run(0, 400, 5);
    check("reached_bit5", falls, 5);
    reset = 1'b1;
    q.delete();
    @(posedge clk); #1;
    check("midrst_outputs", {cmd_ready, rsp_valid, rd_data, ack_rx, arb_lost, err, busy, scl_oe, sda_oe}, 0);
    reset = 1'b0; m_rd = 8'h00;
    @(posedge clk); #1;

    issue(2'd0, 8'h00, 1'b0, 16'd3, mk(0, 0, 0, 1)); run(0, 200, 0);
    check("start_after_rst", lat, 8);
    issue(2'd0, 8'h00, 1'b0, 16'd3, mk(0, 0, 0, 1)); run(0, 200, 0);
    check("rs_lat", lat, 12);
    check("rs_sequence", oe_log, 8'h87);
    issue(2'd3, 8'h00, 1'b0, 16'd3, mk(0, 0, 0, 0)); run(0, 200, 0);
    check("final_stop_lat", lat, 12);
    @(posedge clk); #1;
    check("queue_drained", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
